// File: rtl/brus16_pkg.sv
// Shared constants and state encoding for the rect-table copy engine.
package brus16_pkg;

  localparam int DATA_WIDTH       = 16;
  localparam int MEM_ADDR_WIDTH   = 13;
  localparam int RECT_COUNT       = 64;
  localparam int RECT_WORDS       = 5;
  localparam logic [MEM_ADDR_WIDTH-1:0] RECT_BASE = 13'h1000;
  localparam int RECT_TOTAL_WORDS = RECT_COUNT * RECT_WORDS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } rect_copy_state_t;

endpackage

// File: rtl/rect_copy_addr_gen.sv
// Read side of the rect copy: issues one data-memory read per cycle from
// BASE for TOTAL words, flagging the final read with 'last'.
module rect_copy_addr_gen
  import brus16_pkg::*;
#(
  parameter int MEM_ADDR_WIDTH = brus16_pkg::MEM_ADDR_WIDTH,
  parameter int TOTAL          = brus16_pkg::RECT_TOTAL_WORDS,
  parameter logic [MEM_ADDR_WIDTH-1:0] BASE = brus16_pkg::RECT_BASE
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      abort,
  output logic                      mem_re,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  output logic                      last
);

  localparam int CNT_W = $clog2(TOTAL + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TOTAL - 1);

  logic [CNT_W-1:0]          rd_cnt_q, rd_cnt_d;
  logic                      mem_re_q, mem_re_d;
  logic [MEM_ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;

  // rd_cnt_q is the index of the read currently presented on mem_addr.
  assign last     = mem_re_q && (rd_cnt_q == LAST_CNT);
  assign mem_re   = mem_re_q;
  assign mem_addr = mem_addr_q;

  always_comb begin
    rd_cnt_d   = rd_cnt_q;
    mem_re_d   = mem_re_q;
    mem_addr_d = mem_addr_q;
    if (start) begin
      rd_cnt_d   = '0;
      mem_re_d   = 1'b1;
      mem_addr_d = BASE;
    end else if (mem_re_q) begin
      if (abort || last) begin
        mem_re_d   = 1'b0;
        mem_addr_d = '0;
      end else begin
        rd_cnt_d   = rd_cnt_q + CNT_W'(1);
        mem_addr_d = mem_addr_q + MEM_ADDR_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_cnt_q   <= '0;
      mem_re_q   <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      rd_cnt_q   <= rd_cnt_d;
      mem_re_q   <= mem_re_d;
      mem_addr_q <= mem_addr_d;
    end
  end

endmodule

// File: rtl/rect_copy_engine.sv
// Copies the rect table from CPU data memory into the GPU rect buffer while
// 'copy' is high. Optional RECT_COPY_CHECKSUM_EN adds a sum of written words.
module rect_copy_engine
  import brus16_pkg::*;
#(
  parameter int DATA_WIDTH     = brus16_pkg::DATA_WIDTH,
  parameter int MEM_ADDR_WIDTH = brus16_pkg::MEM_ADDR_WIDTH,
  parameter int RECT_COUNT     = brus16_pkg::RECT_COUNT,
  parameter int RECT_WORDS     = brus16_pkg::RECT_WORDS,
  parameter logic [MEM_ADDR_WIDTH-1:0] RECT_BASE = brus16_pkg::RECT_BASE
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   copy_start,
  input  logic                                   copy,
  output logic                                   mem_re,
  output logic [MEM_ADDR_WIDTH-1:0]              mem_addr,
  input  logic [DATA_WIDTH-1:0]                  mem_rdata,
  output logic                                   gpu_we,
  output logic [$clog2(RECT_COUNT*RECT_WORDS)-1:0] gpu_waddr,
  output logic [DATA_WIDTH-1:0]                  gpu_wdata,
  output logic                                   busy,
  output logic                                   done
`ifdef RECT_COPY_CHECKSUM_EN
  ,
  output logic [DATA_WIDTH-1:0]                  checksum
`endif
);

  localparam int TOTAL   = RECT_COUNT * RECT_WORDS;
  localparam int WADDR_W = $clog2(TOTAL);
  localparam logic [WADDR_W-1:0] LAST_W = WADDR_W'(TOTAL - 1);

  rect_copy_state_t   state_q, state_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               gpu_we_q, gpu_we_d;
  logic [WADDR_W-1:0] wr_cnt_q, wr_cnt_d;
  logic               start, abort, rd_last;

  assign start = (state_q == IDLE) && copy_start && copy;
  assign abort = (state_q != IDLE) && !copy;

  rect_copy_addr_gen #(
    .MEM_ADDR_WIDTH (MEM_ADDR_WIDTH),
    .TOTAL          (TOTAL),
    .BASE           (RECT_BASE)
  ) u_addr_gen (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .abort    (abort),
    .mem_re   (mem_re),
    .mem_addr (mem_addr),
    .last     (rd_last)
  );

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE:    if (start) state_d = READ;
      READ: begin
        if (!copy) begin
          state_d = IDLE;
        end else if (rd_last) begin
          state_d = DRAIN;
          done_d  = 1'b1;
        end
      end
      DRAIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d   = (state_d != IDLE);
    // A read issued in the cycle copy falls is never written back.
    gpu_we_d = mem_re && copy;
    wr_cnt_d = wr_cnt_q;
    if (start) begin
      wr_cnt_d = '0;
    end else if (gpu_we_q && (wr_cnt_q != LAST_W)) begin
      wr_cnt_d = wr_cnt_q + WADDR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      gpu_we_q <= 1'b0;
      wr_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      gpu_we_q <= gpu_we_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  // done lands with the final write; copy dropping in that cycle cancels it.
  assign done      = done_q && copy;
  assign busy      = busy_q;
  assign gpu_we    = gpu_we_q;
  assign gpu_waddr = wr_cnt_q;
  assign gpu_wdata = gpu_we_q ? mem_rdata : '0;

`ifdef RECT_COPY_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [DATA_WIDTH-1:0] csum_q, csum_d;
  logic [DATA_WIDTH-1:0] sum_now;

  always_comb begin
    sum_now = acc_q + gpu_wdata;
    acc_d   = acc_q;
    if (start)         acc_d = '0;
    else if (gpu_we_q) acc_d = sum_now;
    csum_d  = done ? sum_now : csum_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q  <= '0;
      csum_q <= '0;
    end else begin
      acc_q  <= acc_d;
      csum_q <= csum_d;
    end
  end

  assign checksum = done ? sum_now : csum_q;
`endif

endmodule
